// File: rtl/seq_phase_shifter_pkg.sv
// Shared definitions for the sequence phase shifter and the FIR stage that
// feeds it.
//   - state_t         : FSM encoding (ST_FILL = 0, ST_RUN = 1)
//   - SAMPLE_W        : default filtered-sample width
//   - DLY_120_DEFAULT : samples per third of a line period (120 degrees)
//   - ring_sub        : modulo-depth subtraction for circular-buffer read pointers
package seq_phase_shifter_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int SAMPLE_W        = 14;
  localparam int DLY_120_DEFAULT = 67;

  // (p - k) mod depth, for 0 <= p < depth and 0 <= k < depth. The buffer
  // depth is not a power of two, so the pointer cannot simply roll over.
  function automatic int ring_sub(input int p, input int k, input int depth);
    if (p >= k) begin
      return p - k;
    end
    return p + depth - k;
  endfunction

endpackage

// File: rtl/seq_phase_shifter_if.sv
// Sample-stream bundle between the FIR stage, the phase shifter and the
// symmetrical-component combiner.
//   vin, vin_valid              : filtered sample in, one-cycle strobe
//   v0, v120, v240, vout_valid  : aligned triple out, one-cycle strobe
//   filled                      : level, delay line holds 2*DLY samples
//   dbg_state, dbg_wp           : FSM state and write pointer for observation
//
// Handshake: there is no back-pressure. A beat transfers on every cycle in
// which the strobe (vin_valid or vout_valid) is high; the receiver must take
// it that cycle. Data is only meaningful while its strobe is high, although
// v0/v120/v240 hold their last values between strobes.
interface seq_phase_shifter_if
  import seq_phase_shifter_pkg::*;
#(
  parameter int M  = SAMPLE_W,
  parameter int AW = 8
);

  logic signed [M-1:0]  vin;
  logic                 vin_valid;
  logic signed [M-1:0]  v0;
  logic signed [M-1:0]  v120;
  logic signed [M-1:0]  v240;
  logic                 vout_valid;
  logic                 filled;
  state_t               dbg_state;
  logic [AW-1:0]        dbg_wp;

  modport master (
    output vin, vin_valid,
    input  v0, v120, v240, vout_valid, filled, dbg_state, dbg_wp
  );

  modport slave (
    input  vin, vin_valid,
    output v0, v120, v240, vout_valid, filled, dbg_state, dbg_wp
  );

endinterface

// File: rtl/seq_delay_ram.sv
// Single-write, dual-read RAM with registered read ports.
//   clk              : rising-edge clock
//   rst              : synchronous active-high reset of the read registers only
//   we, waddr, wdata : write port
//   re               : read enable; read registers hold while low
//   raddr_a/b        : read addresses
//   rdata_a/b        : registered read data
// A read and a write in the same cycle to the same address returns the old
// contents. The storage array itself is never reset.
module seq_delay_ram #(
  parameter int W     = 14,
  parameter int DEPTH = 135,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[raddr_a[IW-1:0]];
      rdata_b <= mem[raddr_b[IW-1:0]];
    end
  end

endmodule

// File: rtl/seq_phase_shifter.sv
// Produces three time-aligned copies of the filtered sample stream: the
// current sample, the sample DLY strobes earlier (120 degree lag) and the
// sample 2*DLY strobes earlier (240 degree lag).
//   dclk : sample-domain clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of seq_phase_shifter_if (vin/vin_valid in,
//          v0/v120/v240/vout_valid/filled out, dbg_state/dbg_wp observation)
// Latency is one cycle from strobe to output. Output is withheld until the
// delay line has been filled with 2*DLY samples since the last reset.
module seq_phase_shifter
  import seq_phase_shifter_pkg::*;
#(
  parameter int M   = SAMPLE_W,
  parameter int DLY = DLY_120_DEFAULT,
  parameter int AW  = 8
) (
  input  logic                dclk,
  input  logic                rst,
  seq_phase_shifter_if.slave  bus
);

  localparam int            DEPTH    = 2 * DLY + 1;
  localparam logic [AW-1:0] WP_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FILL_TGT = AW'(2 * DLY);

  state_t              state;
  logic [AW-1:0]       wp;
  logic [AW-1:0]       fill_cnt;
  logic [AW-1:0]       ra120;
  logic [AW-1:0]       ra240;
  logic signed [M-1:0] v0_r;
  logic                vout_valid_r;
  logic [M-1:0]        rd120;
  logic [M-1:0]        rd240;

  // Both read addresses trail the write pointer; all three are distinct
  // because 2*DLY < DEPTH.
  assign ra120 = AW'(ring_sub(int'(wp), DLY, DEPTH));
  assign ra240 = AW'(ring_sub(int'(wp), 2 * DLY, DEPTH));

  seq_delay_ram #(
    .W     (M),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (dclk),
    .rst     (rst),
    .we      (bus.vin_valid),
    .waddr   (wp),
    .wdata   (bus.vin),
    .re      (bus.vin_valid),
    .raddr_a (ra120),
    .raddr_b (ra240),
    .rdata_a (rd120),
    .rdata_b (rd240)
  );

  always_ff @(posedge dclk) begin
    if (rst) begin
      state        <= ST_FILL;
      fill_cnt     <= '0;
      wp           <= '0;
      v0_r         <= '0;
      vout_valid_r <= 1'b0;
    end else begin
      vout_valid_r <= 1'b0;
      if (bus.vin_valid) begin
        v0_r         <= bus.vin;
        // Validity follows the state before this strobe, so the first valid
        // triple comes from sample 2*DLY+1.
        vout_valid_r <= (state == ST_RUN);
        wp           <= (wp == WP_LAST) ? '0 : wp + 1'b1;
        case (state)
          ST_FILL: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_TGT - 1'b1) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            // Counter stays saturated at 2*DLY; only rst leaves RUN.
            state <= ST_RUN;
          end
          default: begin
            state <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign bus.v0         = v0_r;
  assign bus.v120       = rd120;
  assign bus.v240       = rd240;
  assign bus.vout_valid = vout_valid_r;
  assign bus.filled     = (state == ST_RUN);
  assign bus.dbg_state  = state;
  assign bus.dbg_wp     = wp;

endmodule
